alu_share_arbiter: RTL

//  Shares one 64-bit ALU between two requesters (req0: execute path, req1: address/branch unit).

---
 rtl/alu_share_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight,
// result captured after ALU_LAT cycles and returned with a locally computed zero flag.
module alu_share_arbiter #(
  parameter int N       = 64,
  parameter int ALU_LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [3:0]   req0_ctrl_i,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [3:0]   req1_ctrl_i,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  output logic [3:0]   alu_ctrl_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  input  logic [N-1:0] alu_w_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [N-1:0] rsp_data_o,
  output logic         rsp_zero_o
);
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [3:0]   ctrl;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_t                op_q, op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [N-1:0]       rsp_data_q, rsp_data_d;
  logic               rsp_zero_q, rsp_zero_d;

  op_t  [NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] grant;
  logic               idle;
  logic               hs;
  logic               gid;

  assign req_op[0] = {req0_ctrl_i, req0_a_i, req0_b_i};
  assign req_op[1] = {req1_ctrl_i, req1_a_i, req1_b_i};
  assign req_vld   = {req1_valid_i, req0_valid_i};

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant = '0;
    if (&req_vld) grant[ptr_q] = 1'b1;
    else          grant = req_vld;
  end

  // Ready is masked during reset so no handshake is ever reported in that cycle.
  assign idle         = (state_q == S_IDLE) && !rst_i;
  assign req0_ready_o = idle & grant[0];
  assign req1_ready_o = idle & grant[1];
  assign hs           = idle && (grant != '0);
  assign gid          = grant[1];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          op_d    = req_op[gid];
          id_d    = gid;
          cnt_d   = CNT_W'(ALU_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_data_d  = alu_w_i;
          rsp_zero_d  = (alu_w_i == '0);
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // Operand registers only change on accept, keeping alu_w stable while waiting.
  assign alu_ctrl_o  = op_q.ctrl;
  assign alu_a_o     = op_q.a;
  assign alu_b_o     = op_q.b;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_zero_o  = rsp_zero_q;

  a_one_ready: assert property (@(posedge clk_i) !(req0_ready_o && req1_ready_o));
  a_rsp_hold:  assert property (@(posedge clk_i) disable iff (rst_i)
                 (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_data_o) && $stable(rsp_id_o)));

endmodule
